alu_trace_capture: RTL and testbench

- Capture/readout end of the ALU interface: samples ALU outputs (result, sign, zero, carry) plus the ALUSel that produced them whenever a capture strobe fires.
- Buffers each sample in a first-word-fall-through FIFO, drained by a host/debug reader over a valid/ready handshake.
- Sits beside the ALU in the KGP_miniRISC datapath as an on-chip, self-checkable trace of ALU activity for bring-up and regression.

---
 rtl/miniRISC_pkg.sv | 27 ++
 rtl/trace_fifo_mem.sv | 20 ++
 rtl/alu_trace_capture.sv | 76 +++++++
 tb/tb_alu_trace_capture.sv | 120 ++++++++++++
 4 files changed

// File: rtl/miniRISC_pkg.sv
// miniRISC_pkg: ALU op encodings and trace entry layout shared by the ALU trace logic
package miniRISC_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOT = 4'b0101,
    ALU_SLA = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_CMP = 4'b1001
  } alu_op_e;
  localparam int TRACE_ENTRY_W = 39;
  localparam int TS_W          = 16;
  localparam int RESULT_LSB    = 0;
  localparam int CARRY_BIT     = 32;
  localparam int ZERO_BIT      = 33;
  localparam int SIGN_BIT      = 34;
  localparam int SEL_LSB       = 35;
  function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(input logic [3:0] sel, input logic sign,
                                                          input logic zero, input logic carry,
                                                          input logic [31:0] result);
    return {sel, sign, zero, carry, result};
  endfunction
endpackage

// File: rtl/trace_fifo_mem.sv
// trace_fifo_mem: trace storage RAM, registered write-first read port with flush-to-zero output
module trace_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W = 39
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // write-first forwarding lets an entry pushed into an empty FIFO appear one cycle later
  always_ff @(posedge clk)
    q <= flush ? '0 : (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/alu_trace_capture.sv
// alu_trace_capture: FWFT trace FIFO of ALU outputs with mask filter and saturating drop counter
// define TRACE_TIMESTAMP_EN to prepend a 16-bit push-cycle timestamp to every entry
module alu_trace_capture
  import miniRISC_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter logic [15:0] CAPTURE_MASK = 16'hFFFF,
  parameter int DROP_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_valid,
  input  logic [3:0]                alu_sel,
  input  logic [31:0]               alu_result,
  input  logic                      alu_sign,
  input  logic                      alu_zero,
  input  logic                      alu_carry,
  input  logic                      clear,
  output logic                      rd_valid,
  input  logic                      rd_ready,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W+TRACE_ENTRY_W-1:0] rd_data,
`else
  output logic [TRACE_ENTRY_W-1:0]  rd_data,
`endif
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic [DROP_W-1:0]         drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int W = $bits(rd_data);
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [LW-1:0] level_n;
  logic [W-1:0] wdata;
  logic flush, qual, push, pop;
  assign flush    = rst | clear;
  assign qual     = cap_valid & CAPTURE_MASK[alu_sel];
  assign pop      = rd_valid & rd_ready;
  assign push     = qual & (!full | pop);
  assign full     = level == LW'(DEPTH);
  assign level_n  = level + LW'(push) - LW'(pop);
  assign rd_ptr_n = rd_ptr + AW'(pop);
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk)
    ts <= rst ? '0 : ts + 1'b1;
  assign wdata = {ts, pack_entry(alu_sel, alu_sign, alu_zero, alu_carry, alu_result)};
`else
  assign wdata = pack_entry(alu_sel, alu_sign, alu_zero, alu_carry, alu_result);
`endif
  always_ff @(posedge clk)
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr_n;
      level    <= level_n;
      rd_valid <= level_n != '0;
      if (qual && !push && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  // the RAM reads ahead at the post-pop pointer so the next entry follows a pop with no bubble
  trace_fifo_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk   (clk),
    .flush (flush),
    .we    (push & !flush),
    .waddr (wr_ptr),
    .raddr (rd_ptr_n),
    .wdata (wdata),
    .q     (rd_data)
  );
endmodule

// File: tb/tb_alu_trace_capture.sv
// tb_alu_trace_capture: scoreboard bench for alu_trace_capture (default build, no timestamp)
module tb_alu_trace_capture;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, cap_valid = 1'b0, rd_ready = 1'b0;
  logic alu_sign = 1'b0, alu_zero = 1'b0, alu_carry = 1'b0;
  logic [3:0] alu_sel = '0;
  logic [31:0] alu_result = '0;
  logic rd_valid, full, m_rd_valid, m_full;
  logic [38:0] rd_data, m_rd_data;
  logic [3:0] level, m_level;
  logic [15:0] drop_cnt, m_drop_cnt;
  int checks = 0, errors = 0, drops = 0;
  logic [38:0] sbq[$];
  always #5 clk = ~clk;
  alu_trace_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .alu_sel(alu_sel), .alu_result(alu_result),
    .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry), .clear(clear),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .level(level), .full(full),
    .drop_cnt(drop_cnt)
  );
  alu_trace_capture #(.DEPTH(DEPTH), .CAPTURE_MASK(16'h0001)) mdut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .alu_sel(alu_sel), .alu_result(alu_result),
    .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_carry(alu_carry), .clear(clear),
    .rd_valid(m_rd_valid), .rd_ready(rd_ready), .rd_data(m_rd_data), .level(m_level), .full(m_full),
    .drop_cnt(m_drop_cnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic cv, input logic [3:0] sel, input logic [31:0] res,
                     input logic [2:0] f, input logic rdy);
    cap_valid = cv;
    alu_sel = sel;
    alu_result = res;
    {alu_sign, alu_zero, alu_carry} = f;
    rd_ready = rdy;
    check("rd_valid", rd_valid, sbq.size() != 0);
    if (sbq.size() != 0) check("rd_data", rd_data, sbq[0]);
    if (rdy && sbq.size() != 0) sbq.delete(0);
    if (cv) begin
      if (sbq.size() < DEPTH) sbq.push_back({sel, f, res});
      else if (drops < 65535) drops++;
    end
    @(posedge clk);
    #1;
    check("level", level, sbq.size());
    check("full", full, sbq.size() == DEPTH);
    check("drop_cnt", drop_cnt, drops);
  endtask
  task automatic flush(input logic r);
    rst = r;
    clear = !r;
    cap_valid = 1'b1;
    alu_sel = 4'h0;
    alu_result = 32'h5A5A;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear = 1'b0;
    cap_valid = 1'b0;
    rd_ready = 1'b0;
    sbq.delete();
    drops = 0;
    check("flush_level", level, 0);
    check("flush_valid", rd_valid, 0);
    check("flush_full", full, 0);
    check("flush_drop", drop_cnt, 0);
    check("flush_data", rd_data, 0);
    check("flush_m_level", m_level, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    flush(1'b1);
    cyc(1'b1, 4'h0, 32'd102, 3'b000, 1'b0);
    check("basic_valid", rd_valid, 1);
    check("basic_data", rd_data, {4'h0, 3'b000, 32'd102});
    check("basic_level", level, 1);
    cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    cyc(1'b1, 4'h1, 32'd0, 3'b010, 1'b0);
    cyc(1'b1, 4'h0, 32'd1391, 3'b001, 1'b0);
    repeat (3) cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    check("zc_empty", rd_valid, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'(i), 32'd1000 + 32'(i), 3'(i), 1'b0);
    check("ovf_full", full, 1);
    check("ovf_level", level, 8);
    check("ovf_drop", drop_cnt, 2);
    cyc(1'b1, 4'h2, 32'hABCD, 3'b100, 1'b1);
    check("fpp_level", level, 8);
    check("fpp_drop", drop_cnt, 2);
    repeat (10) cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    flush(1'b0);
    cyc(1'b1, 4'h1, 32'd5, 3'b000, 1'b0);
    cyc(1'b1, 4'h9, 32'd6, 3'b000, 1'b0);
    check("mask_level", m_level, 0);
    check("mask_drop", m_drop_cnt, 0);
    cyc(1'b1, 4'h0, 32'd55, 3'b000, 1'b0);
    check("mask_kept_level", m_level, 1);
    check("mask_kept_valid", m_rd_valid, 1);
    check("mask_kept_data", m_rd_data, {4'h0, 3'b000, 32'd55});
    repeat (4) cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 4'h3, 32'd2000 + 32'(i), 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 3), 32'd10 + 32'(i), 3'b010, 1'(i));
    flush(1'b0);
    cyc(1'b1, 4'h0, 32'd939, 3'b000, 1'b0);
    check("post_clear_data", rd_data, {4'h0, 3'b000, 32'd939});
    cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 3'($urandom), 1'($urandom_range(0, 2) != 0));
    repeat (10) cyc(1'b0, 4'h0, 32'd0, 3'b000, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
